// File: rtl/comm_frame_tx.sv
// Transmit framer: sends [LEN][TYPE][PAYLOAD...] byte-by-byte through a uart tx handshake.
// Optional trailing XOR checksum byte is enabled by defining COMM_TX_CHECKSUM_EN.
module comm_frame_tx #(
    parameter int MAX_PAYLOAD = 254
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] msg_type,
    input  logic [7:0] payload_len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       send_data,
    input  logic       busy,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_TYPE,
        S_DATA,
        S_WAIT_HI,
        S_WAIT_LO
`ifdef COMM_TX_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef COMM_TX_CHECKSUM_EN
    localparam state_t     AFTER_DATA = S_CSUM;
    localparam logic [7:0] LEN_EXTRA  = 8'd2;
    localparam logic [8:0] LIMIT      = 9'(MAX_PAYLOAD - 1);
`else
    localparam state_t     AFTER_DATA = S_IDLE;
    localparam logic [7:0] LEN_EXTRA  = 8'd1;
    localparam logic [8:0] LIMIT      = 9'(MAX_PAYLOAD);
`endif

    state_t     r_state;
    state_t     r_ret;
    logic [7:0] r_type;
    logic [7:0] r_len;
    logic [7:0] r_cnt;
    logic [7:0] r_tx_data;
    logic       r_send;
    logic       r_frame_busy;
    logic       r_done;
    logic       r_err;
`ifdef COMM_TX_CHECKSUM_EN
    logic [7:0] r_csum;
`endif
    logic       w_len_ok;

    assign w_len_ok   = ({1'b0, payload_len} <= LIMIT);
    // Ready only while the FSM is parked in DATA, which implies no byte in flight.
    assign pl_ready   = (r_state == S_DATA) && !busy;
    assign tx_data    = r_tx_data;
    assign send_data  = r_send;
    assign frame_busy = r_frame_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ret        <= S_IDLE;
            r_type       <= 8'd0;
            r_len        <= 8'd0;
            r_cnt        <= 8'd0;
            r_tx_data    <= 8'd0;
            r_send       <= 1'b0;
            r_frame_busy <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef COMM_TX_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_send <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_type       <= msg_type;
                            r_len        <= payload_len;
                            r_cnt        <= payload_len;
                            r_frame_busy <= 1'b1;
                            r_state      <= S_LEN;
`ifdef COMM_TX_CHECKSUM_EN
                            r_csum       <= msg_type;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    if (!busy) begin
                        r_tx_data <= r_len + LEN_EXTRA;
                        r_send    <= 1'b1;
                        r_ret     <= S_TYPE;
                        r_state   <= S_WAIT_HI;
                    end
                end
                S_TYPE: begin
                    if (!busy) begin
                        r_tx_data <= r_type;
                        r_send    <= 1'b1;
                        r_ret     <= (r_cnt == 8'd0) ? AFTER_DATA : S_DATA;
                        r_state   <= S_WAIT_HI;
                    end
                end
                S_DATA: begin
                    if (pl_valid && !busy) begin
                        r_tx_data <= pl_data;
                        r_send    <= 1'b1;
                        r_cnt     <= r_cnt - 8'd1;
                        r_ret     <= (r_cnt == 8'd1) ? AFTER_DATA : S_DATA;
                        r_state   <= S_WAIT_HI;
`ifdef COMM_TX_CHECKSUM_EN
                        r_csum    <= r_csum ^ pl_data;
`endif
                    end
                end
`ifdef COMM_TX_CHECKSUM_EN
                S_CSUM: begin
                    if (!busy) begin
                        r_tx_data <= r_csum;
                        r_send    <= 1'b1;
                        r_ret     <= S_IDLE;
                        r_state   <= S_WAIT_HI;
                    end
                end
`endif
                S_WAIT_HI: begin
                    if (busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    // A return state of IDLE marks the byte just finished as the frame's last.
                    if (!busy) begin
                        if (r_ret == S_IDLE) begin
                            r_done       <= 1'b1;
                            r_frame_busy <= 1'b0;
                        end
                        r_state <= r_ret;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_frame_tx.sv
// Directed bench for comm_frame_tx with a behavioural uart busy model and payload source queue.
// Honours COMM_TX_CHECKSUM_EN for the expected byte streams.
module tb_comm_frame_tx;

    localparam int BYTE_CYC = 10;
`ifdef COMM_TX_CHECKSUM_EN
    localparam int LIM = 253;
`else
    localparam int LIM = 254;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] msg_type = 8'd0;
    logic [7:0] payload_len = 8'd0;
    logic [7:0] pl_data = 8'd0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       send_data;
    logic       busy;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_err;

    always #5 clk = ~clk;

    comm_frame_tx #(.MAX_PAYLOAD(254)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_type(msg_type),
        .payload_len(payload_len), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .tx_data(tx_data), .send_data(send_data), .busy(busy),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    logic hold = 1'b0;
    logic xfer_flag = 1'b0;
    int sent_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rdy_cnt = 0;
    int consumed = 0;
    int start_cyc = 0;
    int first_cyc = 0;
    logic [7:0] tx_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] mtype;
        logic [7:0] len;
        logic [7:0] pl[4];
        int         n;
        logic [7:0] ex[8];
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart model: busy rises the cycle after send_data and lasts BYTE_CYC cycles
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (send_data) busy_cnt <= BYTE_CYC;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        xfer_flag <= pl_valid && pl_ready;
    end
    assign busy = (busy_cnt != 0) || hold;

    always @(negedge clk) begin
        if (xfer_flag) begin
            void'(pl_q.pop_front());
            consumed++;
        end
        pl_valid = (pl_q.size() > 0);
        pl_data  = pl_valid ? pl_q[0] : 8'h00;
        if (send_data) begin
            if (sent_cnt == 0) first_cyc = cyc;
            tx_q.push_back(tx_data);
            sent_cnt++;
            check("send_while_busy", {31'd0, busy}, 32'd0);
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (pl_ready) rdy_cnt++;
    end

    // Called at negedge+1; holds start for one clock edge.
    task automatic do_start(input logic [7:0] t, input logic [7:0] l);
        start = 1'b1;
        msg_type = t;
        payload_len = l;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk); #1;
        end
        check("frame_done_seen", done_cnt - d0, 32'd1);
    endtask

    task automatic new_frame();
        tx_q.delete();
        exp_q.delete();
        sent_cnt = 0;
        rdy_cnt = 0;
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, "_nbytes"}, tx_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            logic [31:0] act;
            act = (j < tx_q.size()) ? {24'd0, tx_q[j]} : 32'hDEAD;
            if (act !== {24'd0, exp_q[j]})
                check($sformatf("%s_byte%0d", tag, j), act, {24'd0, exp_q[j]});
            else
                total++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d0;
        int s0;
        int c0;
        logic [7:0] cs;

`ifdef COMM_TX_CHECKSUM_EN
        vecs[0] = '{8'h10, 8'd3, '{8'hA1, 8'hB2, 8'hC3, 8'h00}, 6,
                    '{8'h05, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hC0, 8'h00, 8'h00}};
        vecs[1] = '{8'h22, 8'd0, '{8'h00, 8'h00, 8'h00, 8'h00}, 3,
                    '{8'h02, 8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{8'h3C, 8'd1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 4,
                    '{8'h03, 8'h3C, 8'h5A, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{8'hFF, 8'd4, '{8'h00, 8'hFF, 8'h01, 8'h80}, 7,
                    '{8'h06, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h81, 8'h00}};
`else
        vecs[0] = '{8'h10, 8'd3, '{8'hA1, 8'hB2, 8'hC3, 8'h00}, 5,
                    '{8'h04, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{8'h22, 8'd0, '{8'h00, 8'h00, 8'h00, 8'h00}, 2,
                    '{8'h01, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{8'h3C, 8'd1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 3,
                    '{8'h02, 8'h3C, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{8'hFF, 8'd4, '{8'h00, 8'hFF, 8'h01, 8'h80}, 6,
                    '{8'h05, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h00, 8'h00}};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_send_data", {31'd0, send_data}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            new_frame();
            for (int j = 0; j < vecs[v].len; j++) pl_q.push_back(vecs[v].pl[j]);
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].ex[j]);
            e0 = err_cnt;
            d0 = done_cnt;
            do_start(vecs[v].mtype, vecs[v].len);
            check($sformatf("v%0d_frame_busy", v), {31'd0, frame_busy}, 32'd1);
            wait_done(1000);
            repeat (3) @(negedge clk);
            #1;
            cmp_frame($sformatf("v%0d", v));
            check($sformatf("v%0d_done_once", v), done_cnt - d0, 32'd1);
            check($sformatf("v%0d_no_err", v), err_cnt - e0, 32'd0);
            check($sformatf("v%0d_busy_low", v), {31'd0, frame_busy}, 32'd0);
            if (v == 0) check("v0_latency", first_cyc - start_cyc, 32'd2);
            if (vecs[v].len == 0) check($sformatf("v%0d_no_pl_ready", v), rdy_cnt, 32'd0);
            $display("vector %0d: type=%02h len=%0d bytes=%0d", v, vecs[v].mtype, vecs[v].len, tx_q.size());
        end

        // Oversize payload rejections
        for (int k = 0; k < 2; k++) begin
            logic [7:0] bad_len;
            bad_len = (k == 0) ? 8'd255 : 8'(LIM + 1);
            new_frame();
            e0 = err_cnt;
            do_start(8'h33, bad_len);
            check($sformatf("err%0d_pulse", k), {31'd0, frame_err}, 32'd1);
            check($sformatf("err%0d_frame_busy", k), {31'd0, frame_busy}, 32'd0);
            repeat (5) @(negedge clk);
            #1;
            check($sformatf("err%0d_count", k), err_cnt - e0, 32'd1);
            check($sformatf("err%0d_no_send", k), sent_cnt, 32'd0);
            $display("reject: len=%0d err_pulses=%0d", bad_len, err_cnt - e0);
        end

        // Largest accepted payload
        new_frame();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        cs = 8'h5A;
        for (int i = 0; i < LIM; i++) begin
            pl_q.push_back(8'(i));
            exp_q.push_back(8'(i));
            cs = cs ^ 8'(i);
        end
`ifdef COMM_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        e0 = err_cnt;
        do_start(8'h5A, 8'(LIM));
        check("max_accept", {31'd0, frame_busy}, 32'd1);
        wait_done(6000);
        cmp_frame("max");
        check("max_no_err", err_cnt - e0, 32'd0);
        $display("max frame: len=%0d bytes=%0d", LIM, tx_q.size());

        // Payload stall
        new_frame();
        pl_q.push_back(8'h11);
`ifdef COMM_TX_CHECKSUM_EN
        exp_q = '{8'h05, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
`else
        exp_q = '{8'h04, 8'h44, 8'h11, 8'h22, 8'h33};
`endif
        c0 = consumed;
        do_start(8'h44, 8'd3);
        for (int i = 0; i < 200 && consumed == c0; i++) begin
            @(negedge clk); #1;
        end
        check("gap_first_consumed", consumed - c0, 32'd1);
        s0 = sent_cnt;
        repeat (50) @(negedge clk);
        #1;
        check("gap_no_send", sent_cnt, s0);
        pl_q.push_back(8'h22);
        pl_q.push_back(8'h33);
        wait_done(1000);
        cmp_frame("gap");
        $display("stall frame: bytes=%0d", tx_q.size());

        // Reset mid-frame
        new_frame();
        pl_q.push_back(8'hAA);
        pl_q.push_back(8'hBB);
        do_start(8'h66, 8'd2);
        for (int i = 0; i < 200 && sent_cnt < 2; i++) begin
            @(negedge clk); #1;
        end
        check("rstmid_two_sent", sent_cnt, 32'd2);
        reset = 1'b1;
        @(negedge clk); #1;
        check("rstmid_send_data", {31'd0, send_data}, 32'd0);
        check("rstmid_tx_data", {24'd0, tx_data}, 32'd0);
        check("rstmid_frame_busy", {31'd0, frame_busy}, 32'd0);
        check("rstmid_pl_ready", {31'd0, pl_ready}, 32'd0);
        pl_q.delete();
        new_frame();
        pl_q.push_back(8'h7F);
`ifdef COMM_TX_CHECKSUM_EN
        exp_q = '{8'h03, 8'h05, 8'h7F, 8'h7A};
`else
        exp_q = '{8'h02, 8'h05, 8'h7F};
`endif
        reset = 1'b0;
        do_start(8'h05, 8'd1);
        check("rstmid_restart_accept", {31'd0, frame_busy}, 32'd1);
        wait_done(1000);
        cmp_frame("rstmid");
        $display("post-reset frame: bytes=%0d", tx_q.size());

        // uart held busy, ignored start, then back-to-back frames
        new_frame();
        hold = 1'b1;
        pl_q.push_back(8'h99);
`ifdef COMM_TX_CHECKSUM_EN
        exp_q = '{8'h03, 8'h77, 8'h99, 8'hEE};
`else
        exp_q = '{8'h02, 8'h77, 8'h99};
`endif
        e0 = err_cnt;
        do_start(8'h77, 8'd1);
        repeat (20) @(negedge clk);
        #1;
        check("hold_no_send", sent_cnt, 32'd0);
        do_start(8'h01, 8'hFF);
        check("ignored_start_no_err", err_cnt - e0, 32'd0);
        hold = 1'b0;
        wait_done(1000);
        cmp_frame("hold");
        new_frame();
`ifdef COMM_TX_CHECKSUM_EN
        exp_q = '{8'h02, 8'h12, 8'h12};
`else
        exp_q = '{8'h01, 8'h12};
`endif
        do_start(8'h12, 8'd0);
        check("b2b_accept", {31'd0, frame_busy}, 32'd1);
        wait_done(1000);
        cmp_frame("b2b");
        check("b2b_no_pl_ready", rdy_cnt, 32'd0);
        $display("back-to-back frame: bytes=%0d", tx_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
